// File: rtl/sub_serial.sv
// rtl/sub_serial.sv - bit-serial subtractor, a - b one bit per clock, LSB first
//
// Purpose:
//   Computes (a - b) mod 2^WIDTH serially. The borrow ripples through a single
//   flop. Operands are captured on a start edge and shifted right one bit per
//   SUB cycle. Result bits enter the output register from the top, so after
//   WIDTH cycles the first (LSB) bit has reached bit 0. A final borrow and a
//   completion state let downstream control chain or compare results without
//   counting cycles.
//
// Ports:
//   clk         in  1      single clock, rising edge
//   rst         in  1      synchronous active-low reset
//   en          in  1      start request, sampled only in IDLE and DONE
//   a           in  WIDTH  minuend, captured on the start edge
//   b           in  WIDTH  subtrahend, captured on the start edge
//   out         out WIDTH  registered difference, valid while done=1
//   borrow_out  out 1      registered final borrow (a < b unsigned), valid while done=1
//   done        out 1      high while in DONE
//   busy        out 1      high while in SUB

module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic             done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_out;
  logic             r_borrow;
  logic             r_borrow_out;
  logic [CW-1:0]    r_count;

  logic             w_start;
  logic             w_last;
  logic             w_d;
  logic             w_bn;

  // A start is honoured from IDLE and from DONE; DONE restarts skip IDLE.
  assign w_start = en && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last  = (r_state == S_SUB) && (r_count == LAST_COUNT);

  // One full-subtractor slice on the current LSBs.
  assign w_d  = r_a[0] ^ r_b[0] ^ r_borrow;
  assign w_bn = (~r_a[0] & r_b[0]) | (~r_a[0] & r_borrow) | (r_b[0] & r_borrow);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_next_state = S_SUB;
        end
      end
      S_SUB: begin
        if (r_count == LAST_COUNT) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (en) begin
          w_next_state = S_SUB;
        end
      end
      default: begin
        // Unused code 3 falls back to IDLE.
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Outputs decoded purely from the state register.
  always_comb begin
    done = 1'b0;
    busy = 1'b0;
    case (r_state)
      S_SUB:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        done = 1'b0;
        busy = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_out        <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
      r_count      <= '0;
    end else if (w_start) begin
      r_a      <= a;
      r_b      <= b;
      r_out    <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
    end else if (r_state == S_SUB) begin
      r_out    <= {w_d, r_out[WIDTH-1:1]};
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_borrow <= w_bn;
      r_count  <= r_count + 1'b1;
      // borrow_out only moves on the final bit so it stays stable for readers
      // across idle periods and during the next computation.
      if (w_last) begin
        r_borrow_out <= w_bn;
      end
    end
  end

  assign out        = r_out;
  assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_sub_serial.sv
// tb/tb_sub_serial.sv - directed self-checking bench for sub_serial

module tb_sub_serial;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] out;
  logic       borrow_out;
  logic       done;
  logic       busy;

  int n_vec;
  int n_err;

  sub_serial #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .a          (a),
    .b          (b),
    .out        (out),
    .borrow_out (borrow_out),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one operation, optionally scrambling inputs during SUB, then wait
  // (bounded) for done and check latency, busy length and result.
  task automatic run(input logic [7:0] ta, input logic [7:0] tb_v,
                     input logic [7:0] exp_out, input logic exp_bo,
                     input bit scramble);
    int n;
    int nb;
    a  = ta;
    b  = tb_v;
    en = 1'b1;
    tick();
    en = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("out_cleared_on_start", 32'(out), 32'd0);
    n  = 0;
    nb = 0;
    while (!done && n < 20) begin
      if (scramble) begin
        a  = 8'($urandom);
        b  = 8'($urandom);
        en = 1'($urandom);
      end
      nb += int'(busy);
      tick();
      n++;
    end
    en = 1'b0;
    check("latency", 32'(n), 32'd8);
    check("busy_cycles", 32'(nb), 32'd8);
    check("done", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    check("out", 32'(out), 32'(exp_out));
    check("borrow_out", 32'(borrow_out), 32'(exp_bo));
  endtask

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    en  = 1'b0;
    a   = 8'h00;
    b   = 8'h00;
    tick();
    tick();
    check("rst_out", 32'(out), 32'd0);
    check("rst_borrow_out", 32'(borrow_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    run(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    // DONE holds without en.
    tick();
    tick();
    check("done_hold", 32'(done), 32'd1);
    check("out_hold", 32'(out), 32'h37);

    run(8'h23, 8'h5A, 8'hC9, 1'b1, 1'b0);
    run(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    run(8'h80, 8'h7F, 8'h01, 1'b0, 1'b0);

    // Inputs scrambled during SUB must not disturb the result.
    run(8'h5A, 8'h23, 8'h37, 1'b0, 1'b1);

    // Back-to-back with en held high.
    a  = 8'h10;
    b  = 8'h01;
    en = 1'b1;
    tick();
    check("b2b_out_clear1", 32'(out), 32'd0);
    a = 8'h01;
    b = 8'h10;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("b2b_latency1", 32'(n), 32'd8);
    check("b2b_out1", 32'(out), 32'h0F);
    check("b2b_bo1", 32'(borrow_out), 32'd0);
    tick();
    check("b2b_done_pulse", 32'(done), 32'd0);
    check("b2b_busy_restart", 32'(busy), 32'd1);
    check("b2b_out_clear2", 32'(out), 32'd0);
    en = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("b2b_latency2", 32'(n), 32'd8);
    check("b2b_out2", 32'(out), 32'hF1);
    check("b2b_bo2", 32'(borrow_out), 32'd1);

    // Reset after 4 SUB cycles; borrow_out holds 1 until then.
    a  = 8'h5A;
    b  = 8'h23;
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    tick();
    tick();
    check("bo_held_in_sub", 32'(borrow_out), 32'd1);
    check("busy_mid_sub", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_bo", 32'(borrow_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    tick();
    check("midrst_stays_idle", 32'(busy), 32'd0);

    // Reset on the same edge as en: the start is lost.
    rst = 1'b0;
    en  = 1'b1;
    tick();
    rst = 1'b1;
    en  = 1'b0;
    check("rst_en_busy", 32'(busy), 32'd0);
    check("rst_en_done", 32'(done), 32'd0);

    run(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    run(8'h80, 8'h7F, 8'h01, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
